// File: rtl/multichan_link_if.sv
// Bundle of the byte-transport and per-channel client signals of multichan_link.
//   Transport side : send_flag/send_data/sendable (TX byte handshake),
//                    recv_flag/recv_data/recvable (RX byte handshake)
//   Client side    : write_flag/write_data/writable (per-channel TX slots),
//                    read_flag/read_data/readable (per-channel RX slots)
// Per-channel buses pack {length[4:0], data} with channel 0 in the LSBs.
// slave is the link's view; master is the environment's view.
interface multichan_link_if #(
    parameter int unsigned CHANNEL_BIT = 1,
    parameter int unsigned MESSAGE_BIT = 72
);
    localparam int unsigned NCH = 1 << CHANNEL_BIT;
    localparam int unsigned SW  = 5 + MESSAGE_BIT;

    logic                  send_flag;
    logic [7:0]            send_data;
    logic                  sendable;
    logic                  recv_flag;
    logic [7:0]            recv_data;
    logic                  recvable;
    logic [NCH-1:0]        write_flag;
    logic [NCH*SW-1:0]     write_data;
    logic [NCH-1:0]        writable;
    logic [NCH-1:0]        read_flag;
    logic [NCH*SW-1:0]     read_data;
    logic [NCH-1:0]        readable;

    modport slave (
        output send_flag, send_data, recv_flag, read_data, readable, writable,
        input  sendable, recv_data, recvable, read_flag, write_flag, write_data
    );

    modport master (
        input  send_flag, send_data, recv_flag, read_data, readable, writable,
        output sendable, recv_data, recvable, read_flag, write_flag, write_data
    );
endinterface

// File: rtl/multichan_link.sv
// Multiplexes 2^CHANNEL_BIT message channels over one byte stream.
// Frames are a header byte {channel[2:0], length[4:0]} followed by `length`
// payload bytes, least-significant byte first.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : multichan_link_if.slave (transport handshakes + per-channel slots)
// One transmit slot and one receive slot per channel; TX and RX run independently.
module multichan_link #(
    parameter int unsigned CHANNEL_BIT = 1,
    parameter int unsigned MESSAGE_BIT = 72
) (
    input  logic CLK,
    input  logic RST,
    multichan_link_if.slave bus
);
    localparam int unsigned NCH    = 1 << CHANNEL_BIT;
    localparam int unsigned MAXB   = MESSAGE_BIT / 8;
    localparam int unsigned SW     = 5 + MESSAGE_BIT;
    localparam logic [4:0]  MAXB_L = 5'(MAXB);

    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_HDR     = 2'd1;
    localparam logic [1:0] TX_PAY     = 2'd2;

    localparam logic [1:0] RX_HDR     = 2'd0;
    localparam logic [1:0] RX_PAY     = 2'd1;
    localparam logic [1:0] RX_DELIVER = 2'd2;

    // transmit state
    logic [1:0]             tx_state_q, tx_state_d;
    logic [CHANNEL_BIT-1:0] tx_ch_q, tx_ch_d;
    logic [4:0]             tx_idx_q, tx_idx_d;
    logic [NCH-1:0]         tx_full_q, tx_full_d;
    logic [4:0]             tx_len_q  [NCH];
    logic [4:0]             tx_len_d  [NCH];
    logic [MESSAGE_BIT-1:0] tx_data_q [NCH];
    logic [MESSAGE_BIT-1:0] tx_data_d [NCH];

    // receive state
    logic [1:0]             rx_state_q, rx_state_d;
    logic [2:0]             rx_ch_q, rx_ch_d;
    logic [4:0]             rx_len_q, rx_len_d;
    logic [4:0]             rx_idx_q, rx_idx_d;
    logic [MESSAGE_BIT-1:0] rx_buf_q, rx_buf_d;
    logic [NCH-1:0]         rx_full_q, rx_full_d;
    logic [4:0]             rd_len_q  [NCH];
    logic [4:0]             rd_len_d  [NCH];
    logic [MESSAGE_BIT-1:0] rd_data_q [NCH];
    logic [MESSAGE_BIT-1:0] rd_data_d [NCH];

    logic                   tx_fire;
    logic [7:0]             tx_byte;
    logic [CHANNEL_BIT-1:0] tx_sel;
    logic [4:0]             tx_cur_len;
    logic [MESSAGE_BIT-1:0] tx_cur_data;
    logic                   rx_fire;
    logic                   rx_ch_ok;
    logic [CHANNEL_BIT-1:0] rx_ch_idx;

    // lowest-index full transmit slot
    always_comb begin
        tx_sel = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (tx_full_q[i]) tx_sel = CHANNEL_BIT'(i);
        end
    end

    assign tx_cur_len  = tx_len_q[tx_ch_q];
    assign tx_cur_data = tx_data_q[tx_ch_q];

    // transmit slots and framing FSM
    always_comb begin
        tx_state_d = tx_state_q;
        tx_ch_d    = tx_ch_q;
        tx_idx_d   = tx_idx_q;
        tx_full_d  = tx_full_q;
        tx_len_d   = tx_len_q;
        tx_data_d  = tx_data_q;
        tx_fire    = 1'b0;
        tx_byte    = 8'h00;

        // a load only ever targets an empty slot, a drain only a full one
        for (int i = 0; i < int'(NCH); i++) begin
            if (bus.write_flag[i] && !tx_full_q[i]) begin
                tx_full_d[i] = 1'b1;
                tx_len_d[i]  = (bus.write_data[i*SW + MESSAGE_BIT +: 5] > MAXB_L)
                             ? MAXB_L : bus.write_data[i*SW + MESSAGE_BIT +: 5];
                tx_data_d[i] = bus.write_data[i*SW +: MESSAGE_BIT];
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (|tx_full_q) begin
                    tx_ch_d    = tx_sel;
                    tx_state_d = TX_HDR;
                end
            end
            TX_HDR: begin
                tx_byte = {3'(tx_ch_q), tx_cur_len};
                tx_fire = bus.sendable;
                if (tx_fire) begin
                    tx_idx_d = 5'd0;
                    if (tx_cur_len == 5'd0) begin
                        tx_full_d[tx_ch_q] = 1'b0;
                        tx_state_d         = TX_IDLE;
                    end else begin
                        tx_state_d = TX_PAY;
                    end
                end
            end
            TX_PAY: begin
                tx_byte = 8'(tx_cur_data >> {tx_idx_q, 3'b000});
                tx_fire = bus.sendable;
                if (tx_fire) begin
                    if (tx_idx_q == tx_cur_len - 5'd1) begin
                        tx_full_d[tx_ch_q] = 1'b0;
                        tx_state_d         = TX_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 5'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign rx_ch_ok  = ({1'b0, rx_ch_q} < 4'(NCH));
    assign rx_ch_idx = rx_ch_q[CHANNEL_BIT-1:0];

    // receive parser and per-channel delivery
    always_comb begin
        rx_state_d = rx_state_q;
        rx_ch_d    = rx_ch_q;
        rx_len_d   = rx_len_q;
        rx_idx_d   = rx_idx_q;
        rx_buf_d   = rx_buf_q;
        rx_full_d  = rx_full_q;
        rd_len_d   = rd_len_q;
        rd_data_d  = rd_data_q;
        rx_fire    = 1'b0;

        for (int i = 0; i < int'(NCH); i++) begin
            if (bus.read_flag[i]) rx_full_d[i] = 1'b0;
        end

        case (rx_state_q)
            RX_HDR: begin
                // no byte is taken from the transport while reset is held
                rx_fire = bus.recvable & ~RST;
                if (rx_fire) begin
                    rx_ch_d    = bus.recv_data[7:5];
                    rx_len_d   = bus.recv_data[4:0];
                    rx_idx_d   = 5'd0;
                    rx_buf_d   = '0;
                    rx_state_d = (bus.recv_data[4:0] == 5'd0) ? RX_DELIVER : RX_PAY;
                end
            end
            RX_PAY: begin
                rx_fire = bus.recvable & ~RST;
                if (rx_fire) begin
                    // bytes beyond the payload width are swallowed
                    if (rx_idx_q < MAXB_L) begin
                        rx_buf_d = rx_buf_q
                                 | (MESSAGE_BIT'(bus.recv_data) << {rx_idx_q, 3'b000});
                    end
                    if (rx_idx_q == rx_len_q - 5'd1) begin
                        rx_state_d = RX_DELIVER;
                    end else begin
                        rx_idx_d = rx_idx_q + 5'd1;
                    end
                end
            end
            RX_DELIVER: begin
                if (!rx_ch_ok) begin
                    rx_state_d = RX_HDR;
                end else if (!rx_full_q[rx_ch_idx] || bus.read_flag[rx_ch_idx]) begin
                    rx_full_d[rx_ch_idx] = 1'b1;
                    rd_len_d[rx_ch_idx]  = rx_len_q;
                    rd_data_d[rx_ch_idx] = rx_buf_q;
                    rx_state_d           = RX_HDR;
                end
            end
            default: rx_state_d = RX_HDR;
        endcase
    end

    // state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state_q <= TX_IDLE;
            tx_ch_q    <= '0;
            tx_idx_q   <= '0;
            tx_full_q  <= '0;
            rx_state_q <= RX_HDR;
            rx_ch_q    <= '0;
            rx_len_q   <= '0;
            rx_idx_q   <= '0;
            rx_buf_q   <= '0;
            rx_full_q  <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                tx_len_q[i]  <= '0;
                tx_data_q[i] <= '0;
                rd_len_q[i]  <= '0;
                rd_data_q[i] <= '0;
            end
        end else begin
            tx_state_q <= tx_state_d;
            tx_ch_q    <= tx_ch_d;
            tx_idx_q   <= tx_idx_d;
            tx_full_q  <= tx_full_d;
            rx_state_q <= rx_state_d;
            rx_ch_q    <= rx_ch_d;
            rx_len_q   <= rx_len_d;
            rx_idx_q   <= rx_idx_d;
            rx_buf_q   <= rx_buf_d;
            rx_full_q  <= rx_full_d;
            for (int i = 0; i < int'(NCH); i++) begin
                tx_len_q[i]  <= tx_len_d[i];
                tx_data_q[i] <= tx_data_d[i];
                rd_len_q[i]  <= rd_len_d[i];
                rd_data_q[i] <= rd_data_d[i];
            end
        end
    end

    assign bus.send_flag = tx_fire;
    assign bus.send_data = tx_byte;
    assign bus.recv_flag = rx_fire;
    // masking by the pop lets a client registering its pop off readable avoid a double pop
    assign bus.readable  = rx_full_q & ~bus.read_flag;
    assign bus.writable  = ~tx_full_q & ~bus.write_flag;

    for (genvar g = 0; g < int'(NCH); g++) begin : g_rd
        assign bus.read_data[g*SW +: SW] = {rd_len_q[g], rd_data_q[g]};
    end
endmodule

// File: tb/tb_multichan_link.sv
// Self-checking bench for multichan_link: directed frames plus randomized
// traffic against a queue-based frame model of the transport and clients.
module tb_multichan_link;
    localparam int unsigned CB   = 1;
    localparam int unsigned MB   = 72;
    localparam int unsigned NCH  = 2;
    localparam int unsigned MAXB = 9;
    localparam int unsigned SW   = 77;
    localparam int unsigned NWR  = 50;

    logic CLK = 1'b0;
    logic RST;

    multichan_link_if #(.CHANNEL_BIT(CB), .MESSAGE_BIT(MB)) bus();
    multichan_link #(.CHANNEL_BIT(CB), .MESSAGE_BIT(MB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int n_recv   = 0;
    int n_send   = 0;
    bit tx_en    = 1'b1;
    bit tx_rand  = 1'b0;
    bit rx_rand  = 1'b0;
    logic [7:0]    rx_src[$];
    logic [7:0]    tx_sink[$];
    logic [SW-1:0] exp_rx[NCH][$];
    logic [SW-1:0] exp_tx[NCH][$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_transport();
        bus.sendable  = tx_en && (!tx_rand || $urandom_range(0, 3) != 0);
        bus.recvable  = (rx_src.size() != 0) && (!rx_rand || $urandom_range(0, 3) != 0);
        bus.recv_data = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
    endtask

    // one clock: sample at negedge, clear pulses and update transport after posedge
    task automatic tick();
        bit take;
        logic [7:0] dummy;
        @(negedge CLK);
        if (bus.send_flag) begin
            tx_sink.push_back(bus.send_data);
            n_send++;
        end
        take = bus.recv_flag;
        if (take) n_recv++;
        @(posedge CLK);
        #1;
        bus.write_flag = '0;
        bus.read_flag  = '0;
        if (take && rx_src.size() != 0) dummy = rx_src.pop_front();
        drive_transport();
        #1;
    endtask

    function automatic logic [SW-1:0] rd(input int ch);
        return bus.read_data[ch*SW +: SW];
    endfunction

    function automatic logic [SW-1:0] msg(input logic [4:0] len, input logic [MB-1:0] data);
        return {len, data};
    endfunction

    function automatic logic [127:0] pack(input int start, input int n);
        logic [127:0] r = '0;
        for (int k = 0; k < n; k++) r = (r << 8) | 128'(tx_sink[start + k]);
        return r;
    endfunction

    function automatic logic [MB-1:0] mask(input logic [MB-1:0] data, input int len);
        logic [MB-1:0] r = '0;
        for (int k = 0; k < int'(MAXB); k++) if (k < len) r[k*8 +: 8] = data[k*8 +: 8];
        return r;
    endfunction

    task automatic wr(input int ch, input logic [4:0] len, input logic [MB-1:0] data);
        bus.write_flag[ch] = 1'b1;
        bus.write_data[ch*SW +: SW] = {len, data};
    endtask

    task automatic pop(input int ch);
        bus.read_flag[ch] = 1'b1;
        tick();
    endtask

    task automatic wait_readable(input int ch, input string tag);
        for (int c = 0; c < 100 && !bus.readable[ch]; c++) tick();
        check(tag, 128'(bus.readable[ch]), 128'(1));
    endtask

    task automatic wait_sink(input int n, input string tag);
        for (int c = 0; c < 200 && tx_sink.size() < n; c++) tick();
        check(tag, 128'(tx_sink.size()), 128'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MB-1:0] d;
        int wlen, ln, ch, n_wr, p, n_frames;
        bit done;

        RST = 1'b1;
        bus.write_flag = '0;
        bus.read_flag  = '0;
        bus.write_data = '0;
        bus.sendable   = 1'b0;
        bus.recvable   = 1'b0;
        bus.recv_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_readable", 128'(bus.readable), 128'(0));
        check("rst_writable", 128'(bus.writable), 128'(2'b11));
        check("rst_send_flag", 128'(bus.send_flag), 128'(0));
        check("rst_recv_flag", 128'(bus.recv_flag), 128'(0));
        check("rst_read_data", 128'(bus.read_data), 128'(0));
        RST = 1'b0;
        tick();

        // byte stream 04 78 56 34 12 on channel 0
        n_recv = 0;
        rx_src = '{8'h04, 8'h78, 8'h56, 8'h34, 8'h12};
        wait_readable(0, "rx4_ready");
        check("rx4_recv_count", 128'(n_recv), 128'(5));
        check("rx4_data", 128'(rd(0)), 128'(msg(5'd4, 72'h12345678)));
        check("rx4_ch1_idle", 128'(bus.readable[1]), 128'(0));
        bus.read_flag[0] = 1'b1;
        #1;
        check("rx4_pop_mask", 128'(bus.readable[0]), 128'(0));
        tick();
        check("rx4_popped", 128'(bus.readable), 128'(0));
        check("rx4_stable", 128'(rd(0)), 128'(msg(5'd4, 72'h12345678)));

        // transmit {4, DEADBEEF} on channel 0
        tx_sink.delete();
        wr(0, 5'd4, 72'hDEADBEEF);
        #1;
        check("tx4_writable_mask", 128'(bus.writable[0]), 128'(0));
        tick();
        check("tx4_slot_full", 128'(bus.writable[0]), 128'(0));
        wait_sink(5, "tx4_count");
        check("tx4_bytes", pack(0, 5), 128'(40'h04EFBEADDE));
        check("tx4_slot_empty", 128'(bus.writable), 128'(2'b11));

        // simultaneous writes: channel 0 goes first
        tx_sink.delete();
        wr(1, 5'd3, 72'hA1A2A3);
        wr(0, 5'd2, 72'hB1B2);
        tick();
        wait_sink(3, "arb_first_count");
        check("arb_first", pack(0, 3), 128'(24'h02B2B1));
        check("arb_ch1_held", 128'(bus.writable[1]), 128'(0));
        wait_sink(7, "arb_total_count");
        check("arb_stream", pack(0, 7), 128'(56'h02B2B123A3A2A1));
        check("arb_writable", 128'(bus.writable), 128'(2'b11));

        // transport not ready: nothing may go out
        tx_en = 1'b0;
        tx_sink.delete();
        wr(0, 5'd1, 72'h55);
        repeat (20) tick();
        check("nosend_count", 128'(tx_sink.size()), 128'(0));
        tx_en = 1'b1;
        wait_sink(2, "nosend_resume_count");
        check("nosend_resume", pack(0, 2), 128'(16'h0155));

        // zero-length frames both ways, and length clamping
        n_recv = 0;
        rx_src = '{8'h00};
        wait_readable(0, "rx0_ready");
        check("rx0_recv_count", 128'(n_recv), 128'(1));
        check("rx0_data", 128'(rd(0)), 128'(0));
        pop(0);
        tx_sink.delete();
        wr(1, 5'd0, {72{1'b1}});
        wait_sink(1, "tx0_count");
        repeat (4) tick();
        check("tx0_single", 128'(tx_sink.size()), 128'(1));
        check("tx0_header", 128'(tx_sink[0]), 128'(8'h20));
        tx_sink.delete();
        wr(0, 5'd31, 72'h010203040506070809);
        wait_sink(10, "clamp_count");
        repeat (4) tick();
        check("clamp_total", 128'(tx_sink.size()), 128'(10));
        check("clamp_header", 128'(tx_sink[0]), 128'(8'h09));
        check("clamp_payload", pack(1, 9), 128'(72'h090807060504030201));

        // frame for non-existent channel 5 is swallowed
        n_recv = 0;
        rx_src = '{8'hA2, 8'h11, 8'h22, 8'h21, 8'h77};
        wait_readable(1, "badch_ready");
        check("badch_recv_count", 128'(n_recv), 128'(5));
        check("badch_ch0_idle", 128'(bus.readable[0]), 128'(0));
        check("badch_ch1_data", 128'(rd(1)), 128'(msg(5'd1, 72'h77)));
        check("badch_ch0_data", 128'(rd(0)), 128'(0));
        pop(1);

        // backpressure: second frame waits for the single pop
        n_recv = 0;
        rx_src = '{8'h01, 8'hAA, 8'h01, 8'hBB};
        repeat (30) tick();
        check("bp_readable", 128'(bus.readable[0]), 128'(1));
        check("bp_consumed", 128'(rx_src.size()), 128'(0));
        rx_src.push_back(8'h01);
        rx_src.push_back(8'hCC);
        repeat (10) tick();
        check("bp_stalled", 128'(rx_src.size()), 128'(2));
        check("bp_no_recv", 128'(bus.recv_flag), 128'(0));
        check("bp_recv_count", 128'(n_recv), 128'(4));
        check("bp_first", 128'(rd(0)), 128'(msg(5'd1, 72'hAA)));
        pop(0);
        check("bp_refilled", 128'(bus.readable[0]), 128'(1));
        check("bp_second", 128'(rd(0)), 128'(msg(5'd1, 72'hBB)));
        pop(0);
        wait_readable(0, "bp_third_ready");
        check("bp_third", 128'(rd(0)), 128'(msg(5'd1, 72'hCC)));
        pop(0);
        check("bp_drained", 128'(bus.readable), 128'(0));

        // asynchronous reset mid-frame
        tx_en = 1'b0;
        wr(0, 5'd5, 72'h1122334455);
        tick();
        rx_src = '{8'h21, 8'h66, 8'h03, 8'h01, 8'h02};
        for (int c = 0; c < 50 && rx_src.size() != 0; c++) tick();
        check("mid_consumed", 128'(rx_src.size()), 128'(0));
        check("mid_pre_readable", 128'(bus.readable), 128'(2'b10));
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_readable", 128'(bus.readable), 128'(0));
        check("mid_rst_writable", 128'(bus.writable), 128'(2'b11));
        check("mid_rst_send_flag", 128'(bus.send_flag), 128'(0));
        check("mid_rst_recv_flag", 128'(bus.recv_flag), 128'(0));
        check("mid_rst_read_data", 128'(bus.read_data), 128'(0));
        tick();
        tick();
        RST = 1'b0;
        tx_en = 1'b1;
        tx_sink.delete();
        n_recv = 0;
        rx_src = '{8'h02, 8'h33, 8'h44};
        wait_readable(0, "mid_after_ready");
        check("mid_after_data", 128'(rd(0)), 128'(msg(5'd2, 72'h4433)));
        check("mid_after_count", 128'(n_recv), 128'(3));
        check("mid_tx_abandoned", 128'(tx_sink.size()), 128'(0));
        pop(0);

        // randomized traffic on both paths against the frame model
        tx_rand = 1'b1;
        rx_rand = 1'b1;
        tx_sink.delete();
        for (int f = 0; f < 40; f++) begin
            ch = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
            ln = int'($urandom_range(0, MAXB));
            rx_src.push_back({3'(ch), 5'(ln)});
            d = '0;
            for (int k = 0; k < ln; k++) begin
                d[k*8 +: 8] = 8'($urandom);
                rx_src.push_back(d[k*8 +: 8]);
            end
            if (ch < int'(NCH)) exp_rx[ch].push_back(msg(5'(ln), d));
        end
        n_wr = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (bus.readable[c] && $urandom_range(0, 2) == 0) begin
                    if (exp_rx[c].size() == 0) begin
                        check("rand_rx_extra", 128'(rd(c)), 128'(0));
                    end else begin
                        check("rand_rx", 128'(rd(c)), 128'(exp_rx[c].pop_front()));
                    end
                    bus.read_flag[c] = 1'b1;
                end
                if (n_wr < int'(NWR) && bus.writable[c] && $urandom_range(0, 2) == 0) begin
                    wlen = int'($urandom_range(0, 31));
                    d = {8'($urandom), $urandom, $urandom};
                    wr(c, 5'(wlen), d);
                    if (wlen > int'(MAXB)) wlen = int'(MAXB);
                    exp_tx[c].push_back(msg(5'(wlen), mask(d, wlen)));
                    n_wr++;
                end
            end
            tick();
            done = (n_wr == int'(NWR)) && (rx_src.size() == 0) && (bus.writable == 2'b11)
                && (exp_rx[0].size() == 0) && (exp_rx[1].size() == 0);
        end
        check("rand_done", 128'(done), 128'(1));

        p = 0;
        n_frames = 0;
        while (p < tx_sink.size()) begin
            ch = int'(tx_sink[p][7:5]);
            ln = int'(tx_sink[p][4:0]);
            p++;
            d = '0;
            for (int k = 0; k < ln; k++) begin
                if (p < tx_sink.size() && k < int'(MAXB)) d[k*8 +: 8] = tx_sink[p];
                p++;
            end
            n_frames++;
            if (ch >= int'(NCH) || exp_tx[ch].size() == 0) begin
                check("rand_tx_unexpected", 128'(ch), 128'(NCH));
            end else begin
                check("rand_tx_frame", 128'(msg(5'(ln), d)), 128'(exp_tx[ch].pop_front()));
            end
        end
        check("rand_tx_frames", 128'(n_frames), 128'(NWR));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/multichan_link.md
Name: multichan_link

Overview:
- Multiplexes 2^CHANNEL_BIT independent message channels over one byte-stream transport, normally a UART byte transceiver.
- Each channel carries messages of up to MESSAGE_BIT/8 bytes, with a 5-bit byte-length tag.
- The block frames outgoing messages into header+payload bytes and parses incoming bytes back into per-channel messages.
- It sits between a byte transceiver (below) and client logic such as a memory model or CPU bus bridge (above).

Parameters:
- CHANNEL_BIT, 1, log2 of channel count; legal range 1..3; NCH = 2^CHANNEL_BIT.
- MESSAGE_BIT, 72, payload width per message; a multiple of 8; MESSAGE_BIT/8 ≤ 31 (= MAXB).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- send_flag  out  1  one-cycle strobe: transport accepts send_data this cycle.
- send_data  out  8  byte to transmit.
- recv_flag  out  1  one-cycle strobe: consume recv_data this cycle.
- recv_data  in  8  received byte from transport.
- sendable  in  1  transport can accept a byte this cycle.
- recvable  in  1  transport holds a received byte.
- read_flag  in  NCH  per-channel pop of the receive slot.
- read_data  out  NCH*(5+MESSAGE_BIT)  per-channel {length[4:0], data}; channel i at slice i, channel 0 in the LSBs.
- write_flag  in  NCH  per-channel push into the transmit slot.
- write_data  in  NCH*(5+MESSAGE_BIT)  per-channel {length, data}, same packing as read_data.
- readable  out  NCH  receive slot i full.
- writable  out  NCH  transmit slot i empty.

Behaviour:

Frame format:
- Header byte = {channel[2:0] zero-extended, length[4:0]}.
- Header is followed by `length` payload bytes, LSB first (byte k = data[8k+7:8k]).

Transmit path:
- One holding slot per channel.
- writable[i] = slot_empty[i] & ~write_flag[i] (combinational).
- write_flag[i] with an empty slot loads write_data slice i at the edge. length > MAXB is clamped to MAXB.
- write_flag on a full slot is ignored; slot contents are unchanged.

Transmit FSM (TX_IDLE → TX_HDR → TX_PAY → TX_IDLE):
- TX_IDLE selects the lowest-index full slot.
- send_flag = (TX_HDR | TX_PAY) & sendable (combinational); send_data is the current byte.
- Each send_flag advances one byte, so one byte per cycle is possible.
- After the last byte (or right after the header when length = 0), the slot empties at the same edge and the FSM returns to TX_IDLE.
- A write at edge N yields the header strobe no earlier than cycle N+1.

Receive path:
- One message slot per channel.
- readable[i] = slot_full[i] & ~read_flag[i] (combinational). This lets a client that registers its pop off readable avoid a double pop.
- read_flag on an empty slot is ignored.
- read_data slice i holds the last delivered message and stays stable until overwritten. Data bits at and above 8*length are zero.

Receive FSM (RX_HDR → RX_PAY → RX_DELIVER → RX_HDR):
- recv_flag = (RX_HDR | RX_PAY) & recvable (combinational); the byte is captured on that edge.
- The header latches channel and length. Payload bytes assemble into a shared buffer cleared at each header.
- Bytes with index ≥ MAXB are consumed and discarded.
- Length 0 goes directly to RX_DELIVER.
- RX_DELIVER waits, consuming no bytes, until the target slot is empty or is being popped this cycle. It then writes the slot, sets full, and returns to RX_HDR.
- A header with channel ≥ NCH: the frame is consumed and discarded.
- TX and RX paths are fully independent and may run in the same cycle.

Reset:
- All slots empty; both FSMs idle (TX_IDLE, RX_HDR); read_data zero.
- Resulting outputs: send_flag=0, recv_flag=0, readable=0, writable=all ones.
- Reset mid-frame abandons the frame. The partial RX frame is lost; the TX slot is cleared.

Test Plan:
- Loopback, two instances back-to-back with an always-ready byte pipe, CHANNEL_BIT=1, MESSAGE_BIT=72: write ch0 {len=5, data=0x0_00000010_0} → peer readable[0]=1 after 6 bytes, read_data ch0 = {5, 0x00_00000010_0}; read_flag clears it.
- Direct byte stream on ch0: header 0x04, then bytes 78 56 34 12 → recv_flag pulses 5 times; read_data = {4, 0x12345678}; bytes on send_data for a write {4, 0xDEADBEEF} = 04 EF BE AD DE.
- Arbitration: write ch1 and ch0 in the same cycle → ch0 frame fully sent first, then header 0x2n for ch1; writable[1] stays 0 until its last byte.
- Backpressure: slot0 full, not popped; second ch0 frame arrives → block stalls in RX_DELIVER, recv_flag=0; a single registered read_flag pulse → first message popped exactly once, second delivered next.
- Edge cases: sendable held 0 → no send_flag; length 0 frame → single header byte, delivered data all zero; header channel 5 → frame bytes consumed, no readable change.
- Async reset asserted mid-payload → outputs reset immediately; the next complete frame is received correctly.
